nf_imm_dec_stage: RTL and testbench
===================================

Name: nf_imm_dec_stage

Overview:
- Pipelined immediate-decode stage in front of the nanoFOX sign extender (nf_sign_ex).
- Accepts 32-bit RV32I instruction words over a valid/ready handshake and decodes the opcode to select the immediate type.
- Slices the instruction into the I/U/B/S immediate fields expected by nf_sign_ex, instantiates nf_sign_ex, and registers the extended immediate.
- Uses a 2-entry skid buffer, so backpressure never causes a bubble or a lost word.

Parameters:
- None. Widths are fixed by RV32I.

Ports:
- clk  input  1  core clock; all state updates on the rising edge
- resetn  input  1  reset, asynchronous, active-low
- flush  input  1  synchronous flush; discards all held entries
- in_instr  input  32  instruction word
- in_valid  input  1  in_instr is valid
- in_ready  output  1  stage can accept a word this cycle
- out_imm  output  32  extended immediate (nf_sign_ex imm_ex output, registered)
- out_imm_src  output  2  selected immediate type; I_SEL/U_SEL/B_SEL/S_SEL encodings from nf_cpu.svh
- out_illegal  output  1  opcode has no immediate mapping
- out_valid  output  1  out_* are valid
- out_ready  input  1  consumer accepts the output this cycle

Behaviour:
- Reset (resetn=0, asynchronous):
  - out_valid=0, out_imm=0, out_imm_src=I_SEL, out_illegal=0.
  - in_ready=1.
  - State EMPTY.
- Opcode decode (in_instr[6:0]):
  - 0110111 LUI, 0010111 AUIPC -> U_SEL.
  - 0000011 LOAD, 0010011 OP-IMM, 1100111 JALR -> I_SEL.
  - 0100011 STORE -> S_SEL.
  - 1100011 BRANCH -> B_SEL.
  - Any other opcode -> illegal=1, imm_src=I_SEL, stored immediate forced to 0.
- Field slicing into nf_sign_ex:
  - imm_data_i = instr[31:20].
  - imm_data_u = instr[31:12]. Zero-extended by nf_sign_ex, not shifted.
  - imm_data_s = {instr[31:25], instr[11:7]}.
  - imm_data_b = {instr[31], instr[7], instr[30:25], instr[11:8]}. The result is a halfword offset; the consumer shifts it.
- Decode and sign extension are combinational on in_instr. The result is captured on acceptance (in_valid && in_ready).
- Latency: an accepted word appears on out_* with out_valid=1 on the next cycle.
- Storage: main register (drives out_*) plus skid register.
  - in_ready is registered and equals "skid register empty".
- States:
  - EMPTY: accept -> ONE (word into main).
  - ONE:
    - accept && out_ready -> ONE (main replaced).
    - accept && !out_ready -> TWO (word into skid, in_ready drops next cycle).
    - !accept && out_ready -> EMPTY.
  - TWO (in_ready=0): out_ready -> ONE (skid moves to main in that same edge).
- Output rules:
  - out_* hold stable while out_valid && !out_ready.
  - Ordering is strictly FIFO.
- flush=1: next state EMPTY, out_valid=0, in_ready=1. An input offered in the flush cycle is dropped. flush has priority over every handshake.
- Simultaneous accept and drain in ONE: throughput is 1 word/cycle, with no bubble.
- resetn asserted mid-transfer: all held words are lost and outputs return to reset values immediately (asynchronously).
- Bits of out_imm/out_imm_src/out_illegal are don't-care when out_valid=0 but must not contain X after reset.

Optional Feature:
- Macro: NF_IMM_DEC_STAT_EN.
- Defined:
  - Adds output port stat_cnt [15:0], counting words handed off (out_valid && out_ready && !flush).
  - Wraps 0xFFFF -> 0x0000. Reset to 0, not cleared by flush.
  - Adds output port illegal_cnt [7:0], counting illegal words handed off. Saturates at 0xFF.
- Undefined: neither port nor counter exists. All other behaviour is identical.

Test Plan:
- addi x1,x0,-1 (0xFFF00093), in_valid=1, out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_imm_src=I_SEL, out_illegal=0.
- Back-to-back lui 0x123450B7 then sw 0xFE20AE23, out_ready=1 -> consecutive cycles out_imm=0x00012345 (U_SEL), then 0xFFFFFFFC (S_SEL). in_ready stays 1.
- beq 0xFE000CE3 with out_ready=0 for 3 cycles while a second word 0xFFF00093 is offered:
  - out_imm=0xFFFFFFFC (B_SEL) holds stable.
  - in_ready=0 after the second accept.
  - Release out_ready -> words emerge in order, then in_ready returns to 1.
- Opcode 0x0000007F -> out_illegal=1, out_imm=0x00000000, out_imm_src=I_SEL. With NF_IMM_DEC_STAT_EN, illegal_cnt increments by 1.
- State TWO, then flush=1 for one cycle while in_valid=1 -> out_valid=0 and in_ready=1 next cycle. No stale word ever emerges.
- resetn pulsed low mid-stream (state TWO) -> out_valid=0 and in_ready=1 asynchronously. With NF_IMM_DEC_STAT_EN, stat_cnt=0. Stream resumes correctly after release.

Source files
------------

// File: rtl/nf_imm_dec_stage.sv
// nf_imm_dec_stage: pipelined RV32I immediate-decode stage.
//
// Decodes the opcode of each accepted instruction word into an immediate type.
// It slices the I/U/B/S fields into nf_sign_ex and registers the extended
// immediate. A main register plus a skid register absorb one cycle of
// backpressure, so the stage never inserts a bubble and never drops a word.
//
// Optional feature: define NF_IMM_DEC_STAT_EN to add the stat_cnt (words
// handed off, wrapping) and illegal_cnt (illegal words handed off,
// saturating) output ports.
//
// Ports:
//   clk, resetn           clock, asynchronous active-low reset
//   flush                 synchronous flush, drops every held word
//   in_instr/in_valid     upstream word and its valid
//   in_ready              registered, high while the skid register is empty
//   out_imm               extended immediate (0 for illegal opcodes)
//   out_imm_src           immediate type: I_SEL/U_SEL/B_SEL/S_SEL
//   out_illegal           opcode has no immediate mapping
//   out_valid/out_ready   downstream handshake
//   stat_cnt, illegal_cnt handoff counters (NF_IMM_DEC_STAT_EN only)

// Sign extender for the four RV32I immediate formats.
// U is zero-extended and not shifted. B is a halfword offset.
module nf_sign_ex
(
    input  logic [11:0] imm_data_i,
    input  logic [19:0] imm_data_u,
    input  logic [11:0] imm_data_b,
    input  logic [11:0] imm_data_s,
    input  logic [1:0]  imm_src,
    output logic [31:0] imm_ex
);
    always_comb begin
        imm_ex = '0;
        case (imm_src)
            2'b00:   imm_ex = {{20{imm_data_i[11]}}, imm_data_i};
            2'b01:   imm_ex = {12'h000, imm_data_u};
            2'b10:   imm_ex = {{20{imm_data_b[11]}}, imm_data_b};
            default: imm_ex = {{20{imm_data_s[11]}}, imm_data_s};
        endcase
    end
endmodule

module nf_imm_dec_stage
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic [31:0] in_instr,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_imm,
    output logic [1:0]  out_imm_src,
    output logic        out_illegal,
    output logic        out_valid,
`ifdef NF_IMM_DEC_STAT_EN
    output logic [15:0] stat_cnt,
    output logic [7:0]  illegal_cnt,
`endif
    input  logic        out_ready
);
    localparam int unsigned IMM_W = 32;
    localparam int unsigned SRC_W = 2;

    localparam logic [SRC_W-1:0] I_SEL = 2'b00;
    localparam logic [SRC_W-1:0] U_SEL = 2'b01;
    localparam logic [SRC_W-1:0] B_SEL = 2'b10;
    localparam logic [SRC_W-1:0] S_SEL = 2'b11;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [SRC_W-1:0] dec_src;
    logic             dec_ill;
    logic [IMM_W-1:0] sx_imm;
    logic [IMM_W-1:0] dec_imm;

    logic [IMM_W-1:0] skid_imm;
    logic [SRC_W-1:0] skid_src;
    logic             skid_ill;

    logic accept;
    logic handoff;
    logic load_main;
    logic main_from_skid;
    logic load_skid;

    // Opcode to immediate type.
    always_comb begin
        dec_src = I_SEL;
        dec_ill = 1'b0;
        case (in_instr[6:0])
            OP_LUI, OP_AUIPC:          dec_src = U_SEL;
            OP_LOAD, OP_OPIMM, OP_JALR: dec_src = I_SEL;
            OP_STORE:                  dec_src = S_SEL;
            OP_BRANCH:                 dec_src = B_SEL;
            default:                   dec_ill = 1'b1;
        endcase
    end

    nf_sign_ex u_sign_ex
    (
        .imm_data_i (in_instr[31:20]),
        .imm_data_u (in_instr[31:12]),
        .imm_data_b ({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8]}),
        .imm_data_s ({in_instr[31:25], in_instr[11:7]}),
        .imm_src    (dec_src),
        .imm_ex     (sx_imm)
    );

    assign dec_imm = dec_ill ? '0 : sx_imm;
    assign accept  = in_valid && in_ready;
    assign handoff = out_valid && out_ready;

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= ST_EMPTY;
        else         state_q <= state_d;
    end

    // Next state and register load controls; flush overrides every handshake.
    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d   = ST_ONE;
                        load_main = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && out_ready) begin
                        load_main = 1'b1;
                    end else if (accept) begin
                        state_d   = ST_TWO;
                        load_skid = 1'b1;
                    end else if (out_ready) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_ready) begin
                        state_d        = ST_ONE;
                        load_main      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // Handshake flags are registered copies of the next-state occupancy.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            out_valid <= (state_d != ST_EMPTY);
            in_ready  <= (state_d != ST_TWO);
        end
    end

    // Main register drives out_*; it takes the skid entry when draining TWO.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_imm     <= '0;
            out_imm_src <= I_SEL;
            out_illegal <= 1'b0;
        end else if (load_main) begin
            out_imm     <= main_from_skid ? skid_imm : dec_imm;
            out_imm_src <= main_from_skid ? skid_src : dec_src;
            out_illegal <= main_from_skid ? skid_ill : dec_ill;
        end
    end

    // Skid register holds the word accepted while the consumer stalls.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            skid_imm <= '0;
            skid_src <= I_SEL;
            skid_ill <= 1'b0;
        end else if (load_skid) begin
            skid_imm <= dec_imm;
            skid_src <= dec_src;
            skid_ill <= dec_ill;
        end
    end

`ifdef NF_IMM_DEC_STAT_EN
    // Handoff counters: unaffected by flush, cleared only by reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stat_cnt    <= '0;
            illegal_cnt <= '0;
        end else if (handoff && !flush) begin
            stat_cnt <= stat_cnt + 16'(1);
            if (out_illegal && (illegal_cnt != 8'hFF))
                illegal_cnt <= illegal_cnt + 8'(1);
        end
    end
`else
    logic unused_handoff;
    assign unused_handoff = handoff;
`endif

endmodule

// File: tb/tb_nf_imm_dec_stage.sv
// Self-checking bench for nf_imm_dec_stage: a queue-based model of the
// two-deep stage, a per-cycle compare process and directed literal checks.
module tb_nf_imm_dec_stage;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] in_instr = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] out_imm;
    logic [1:0]  out_imm_src;
    logic        out_illegal;
    logic        out_valid;
    logic        out_ready = 1'b0;
`ifdef NF_IMM_DEC_STAT_EN
    logic [15:0] stat_cnt;
    logic [7:0]  illegal_cnt;
    int          m_stat = 0;
    int          m_ill  = 0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [31:0] imm;
        logic [1:0]  src;
        logic        ill;
    } exp_t;

    exp_t q[$];

    nf_imm_dec_stage dut (
        .clk         (clk),
        .resetn      (resetn),
        .flush       (flush),
        .in_instr    (in_instr),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_imm     (out_imm),
        .out_imm_src (out_imm_src),
        .out_illegal (out_illegal),
        .out_valid   (out_valid),
`ifdef NF_IMM_DEC_STAT_EN
        .stat_cnt    (stat_cnt),
        .illegal_cnt (illegal_cnt),
`endif
        .out_ready   (out_ready)
    );

    always #5 clk = ~clk;

    // Expected decode straight from the RV32I immediate formats.
    function automatic exp_t exp_of(input logic [31:0] w);
        exp_t e;
        logic [11:0] f;
        e.imm = 32'h0;
        e.src = 2'd0;
        e.ill = 1'b0;
        case (w[6:0])
            7'h37, 7'h17: begin
                e.src = 2'd1;
                e.imm = w >> 12;
            end
            7'h03, 7'h13, 7'h67: begin
                e.src = 2'd0;
                e.imm = 32'($signed(w) >>> 20);
            end
            7'h23: begin
                e.src = 2'd3;
                f = {w[31:25], w[11:7]};
                e.imm = 32'(signed'(f));
            end
            7'h63: begin
                e.src = 2'd2;
                f = {w[31], w[7], w[30:25], w[11:8]};
                e.imm = 32'(signed'(f));
            end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: at most two words in flight, FIFO order, flush empties it.
    always @(posedge clk) begin
        if (resetn) begin
            if (flush) begin
                q.delete();
            end else begin
                bit acc;
                acc = in_valid && (q.size() < 2);
`ifdef NF_IMM_DEC_STAT_EN
                if (q.size() > 0 && out_ready) begin
                    m_stat = (m_stat + 1) % 65536;
                    if (q[0].ill && m_ill < 255) m_ill++;
                end
`endif
                if (q.size() > 0 && out_ready) void'(q.pop_front());
                if (acc) q.push_back(exp_of(in_instr));
            end
        end
    end

    always @(negedge resetn) begin
        q.delete();
`ifdef NF_IMM_DEC_STAT_EN
        m_stat = 0;
        m_ill  = 0;
`endif
    end

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (resetn) begin
            chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
            chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
            if (q.size() > 0) begin
                chk("out_imm", out_imm, q[0].imm);
                chk("out_imm_src", 32'(out_imm_src), 32'(q[0].src));
                chk("out_illegal", 32'(out_illegal), 32'(q[0].ill));
            end
`ifdef NF_IMM_DEC_STAT_EN
            chk("stat_cnt", 32'(stat_cnt), 32'(m_stat));
            chk("illegal_cnt", 32'(illegal_cnt), 32'(m_ill));
`endif
        end
    end

    task automatic step(input logic v, input logic [31:0] w, input logic ordy, input logic fl);
        in_valid  = v;
        in_instr  = w;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] ADDI = 32'hFFF00093;
    localparam logic [31:0] LUI  = 32'h123450B7;
    localparam logic [31:0] SW   = 32'hFE20AE23;
    localparam logic [31:0] BEQ  = 32'hFE000CE3;
    localparam logic [31:0] BAD  = 32'h0000007F;

    logic [31:0] tbl [0:8];
    exp_t pin;

    initial begin
        tbl[0] = ADDI;         tbl[1] = LUI;          tbl[2] = SW;
        tbl[3] = BEQ;          tbl[4] = BAD;          tbl[5] = 32'h00412083;
        tbl[6] = 32'h00001117; tbl[7] = 32'h000080E7; tbl[8] = 32'h00209463;

        // Pin the model itself with hand-computed values.
        pin = exp_of(SW);
        chk("model_sw", pin.imm, 32'hFFFFFFFC);
        pin = exp_of(BEQ);
        chk("model_beq", pin.imm, 32'hFFFFFFFC);
        pin = exp_of(32'h00001117);
        chk("model_auipc", pin.imm, 32'h00000001);

        // Reset values.
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_out_imm", out_imm, 32'h0);
        chk("rst_out_imm_src", 32'(out_imm_src), 32'h0);
        chk("rst_out_illegal", 32'(out_illegal), 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // addi x1,x0,-1.
        step(1'b1, ADDI, 1'b1, 1'b0);
        @(negedge clk);
        chk("addi_valid", 32'(out_valid), 32'h1);
        chk("addi_imm", out_imm, 32'hFFFFFFFF);
        chk("addi_src", 32'(out_imm_src), 32'h0);
        chk("addi_ill", 32'(out_illegal), 32'h0);

        // Back-to-back lui, sw.
        step(1'b1, LUI, 1'b1, 1'b0);
        @(negedge clk);
        chk("lui_imm", out_imm, 32'h00012345);
        chk("lui_src", 32'(out_imm_src), 32'h1);
        chk("lui_in_ready", 32'(in_ready), 32'h1);
        step(1'b1, SW, 1'b1, 1'b0);
        @(negedge clk);
        chk("sw_imm", out_imm, 32'hFFFFFFFC);
        chk("sw_src", 32'(out_imm_src), 32'h3);
        chk("sw_in_ready", 32'(in_ready), 32'h1);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // beq under backpressure, second word into skid.
        step(1'b1, BEQ, 1'b0, 1'b0);
        step(1'b1, ADDI, 1'b0, 1'b0);
        @(negedge clk);
        chk("bp_in_ready", 32'(in_ready), 32'h0);
        chk("bp_imm", out_imm, 32'hFFFFFFFC);
        chk("bp_src", 32'(out_imm_src), 32'h2);
        step(1'b1, SW, 1'b0, 1'b0);
        @(negedge clk);
        chk("bp_hold_imm", out_imm, 32'hFFFFFFFC);
        chk("bp_hold_src", 32'(out_imm_src), 32'h2);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        chk("bp_second_imm", out_imm, 32'hFFFFFFFF);
        chk("bp_ready_back", 32'(in_ready), 32'h1);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        chk("bp_drained", 32'(out_valid), 32'h0);

        // Illegal opcode.
        step(1'b1, BAD, 1'b1, 1'b0);
        @(negedge clk);
        chk("ill_flag", 32'(out_illegal), 32'h1);
        chk("ill_imm", out_imm, 32'h0);
        chk("ill_src", 32'(out_imm_src), 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
`ifdef NF_IMM_DEC_STAT_EN
        @(negedge clk);
        chk("ill_cnt_lit", 32'(illegal_cnt), 32'h1);
`endif

        // Flush from TWO with a word offered.
        step(1'b1, LUI, 1'b0, 1'b0);
        step(1'b1, SW, 1'b0, 1'b0);
        step(1'b1, BEQ, 1'b0, 1'b1);
        @(negedge clk);
        chk("flush_valid", 32'(out_valid), 32'h0);
        chk("flush_in_ready", 32'(in_ready), 32'h1);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        chk("flush_no_stale", 32'(out_valid), 32'h0);

        // Asynchronous reset in TWO.
        step(1'b1, LUI, 1'b0, 1'b0);
        step(1'b1, SW, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'h0);
        chk("arst_in_ready", 32'(in_ready), 32'h1);
`ifdef NF_IMM_DEC_STAT_EN
        chk("arst_stat", 32'(stat_cnt), 32'h0);
`endif
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        step(1'b1, ADDI, 1'b1, 1'b0);
        @(negedge clk);
        chk("resume_imm", out_imm, 32'hFFFFFFFF);

        // Mixed traffic: stalls, gaps, one flush.
        for (int i = 0; i < 48; i++)
            step((i % 3) != 2, tbl[i % 9], (i % 4) != 0, i == 25);
        for (int i = 0; i < 4; i++)
            step(1'b0, 32'h0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
